// File: rtl/sm_stream_accumulator.sv
// sm_sa_fifo: generic first-word-fall-through FIFO with wrap-bit pointers.
// Latency: a pushed word is visible at dout_o the cycle after the push edge.
// Backpressure: full_o/empty_o are pre-edge flags; the caller gates push/pop on them.
module sm_sa_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (AW+1)'(1);
      if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
endmodule

// sm_stream_accumulator: buffers sign-magnitude samples, sums COUNT_MAX of them per frame with saturation.
// Latency: COUNT_MAX+1 cycles from the first push edge to out_valid under a continuous stream.
// Backpressure: in_ready = enable & !full; a frame held in HOLD stops pops so the FIFO fills.
module sm_stream_accumulator #(
  parameter int ACC_W      = 16,
  parameter int COUNT_MAX  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_overflow,
  output logic             out_saturated,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [ACC_W-1:0] MAX_V    = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V    = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [7:0]       LAST_CNT = 8'(COUNT_MAX);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             sat_q, sat_d;

  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic [8:0]       head;
  logic [ACC_W-1:0] mag_ext, value, sat_sum;
  logic [ACC_W:0]   sum_w;
  logic             pos_clamp, neg_clamp;

  assign in_ready = enable & ~fifo_full & ~reset;
  assign push     = in_valid & in_ready;

  sm_sa_fifo #(.W(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({in_overflow, in_data}),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sign-magnitude to two's complement; negative zero (8'h80) naturally maps to 0.
  assign mag_ext = {{(ACC_W-7){1'b0}}, head[6:0]};
  assign value   = head[7] ? -mag_ext : mag_ext;

  // One extra bit of headroom; a mismatch of the top two bits means the true sum left the range.
  assign sum_w     = {acc_q[ACC_W-1], acc_q} + {value[ACC_W-1], value};
  assign pos_clamp = ~sum_w[ACC_W] &  sum_w[ACC_W-1];
  assign neg_clamp =  sum_w[ACC_W] & ~sum_w[ACC_W-1];
  assign sat_sum   = pos_clamp ? MAX_V : (neg_clamp ? MIN_V : sum_w[ACC_W-1:0]);

  // Frame state, accumulator, sample count and sticky flags; acc_q doubles as the held result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
    end
  end

  // Next state: start a frame on the first pop, accumulate until COUNT_MAX, hold until accepted.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    sat_d   = sat_q;
    pop     = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            acc_d   = value;
            count_d = 8'd1;
            ovf_d   = head[8];
            sat_d   = 1'b0;
            state_d = (COUNT_MAX == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            acc_d   = sat_sum;
            count_d = count_q + 8'd1;
            ovf_d   = ovf_q | head[8];
            sat_d   = sat_q | pos_clamp | neg_clamp;
            if (count_q + 8'd1 == LAST_CNT) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign out_valid     = (state_q == HOLD);
  assign out_sum       = acc_q;
  assign out_overflow  = ovf_q;
  assign out_saturated = sat_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_sm_stream_accumulator.sv
// Bench for sm_stream_accumulator: three instances (default, ACC_W=9, COUNT_MAX=1) with a
// frame-level reference model checked whenever out_valid is high, plus directed literal checks.
module tb_sm_stream_accumulator;
  typedef logic [8:0] smp_q_t [$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        enable [3];
  logic        in_valid [3];
  logic        in_ready [3];
  logic [7:0]  in_data [3];
  logic        in_ovf [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic        out_ovf [3];
  logic        out_sat [3];
  logic        busy [3];
  logic [15:0] s0, s2;
  logic [8:0]  s1;
  logic signed [31:0] osum [3];

  assign osum[0] = {{16{s0[15]}}, s0};
  assign osum[1] = {{23{s1[8]}}, s1};
  assign osum[2] = {{16{s2[15]}}, s2};

  sm_stream_accumulator #(.ACC_W(16), .COUNT_MAX(8), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset(rst), .enable(enable[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_overflow(in_ovf[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(s0), .out_overflow(out_ovf[0]), .out_saturated(out_sat[0]), .busy(busy[0]));
  sm_stream_accumulator #(.ACC_W(9), .COUNT_MAX(8), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset(rst), .enable(enable[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_overflow(in_ovf[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(s1), .out_overflow(out_ovf[1]), .out_saturated(out_sat[1]), .busy(busy[1]));
  sm_stream_accumulator #(.ACC_W(16), .COUNT_MAX(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset(rst), .enable(enable[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_overflow(in_ovf[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_sum(s2), .out_overflow(out_ovf[2]), .out_saturated(out_sat[2]), .busy(busy[2]));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pushes [3];
  int frames [3];
  logic [10:0] sq [$];  // accepted samples tagged {instance, overflow, data}

  always @(posedge clk) cyc++;

  function automatic int cm(input int d);
    return (d == 2) ? 1 : 8;
  endfunction

  function automatic int accw(input int d);
    return (d == 1) ? 9 : 16;
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm, input string msg);
    n_vec++;
    n_err++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  // Oldest n accepted samples belonging to instance d.
  function automatic void first_n(input int d, input int n, output smp_q_t f);
    f = {};
    for (int i = 0; i < sq.size() && f.size() < n; i++)
      if (sq[i][10:9] == 2'(d)) f.push_back(sq[i][8:0]);
  endfunction

  function automatic void drop_n(input int d, input int n);
    logic [10:0] nq [$];
    int taken;
    taken = 0;
    foreach (sq[i]) begin
      if (sq[i][10:9] == 2'(d) && taken < n) taken++;
      else nq.push_back(sq[i]);
    end
    sq = nq;
  endfunction

  function automatic int pending(input int d);
    int c;
    c = 0;
    foreach (sq[i]) if (sq[i][10:9] == 2'(d)) c++;
    return c;
  endfunction

  // Frame result from plain integer arithmetic: add each value, clamp to the w-bit signed range.
  function automatic void model(input smp_q_t f, input int n, input int w,
                                output longint s, output logic ov, output logic sat);
    longint hi, lo, v;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    s = 0; ov = 1'b0; sat = 1'b0;
    for (int i = 0; i < n; i++) begin
      v = longint'(f[i][6:0]);
      if (f[i][7]) v = -v;
      s = (i == 0) ? v : s + v;
      if (s > hi) begin s = hi; sat = 1'b1; end
      else if (s < lo) begin s = lo; sat = 1'b1; end
      ov = ov | f[i][8];
    end
  endfunction

  // Scoreboard: inputs only change just after posedges, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    smp_q_t f;
    longint es;
    logic eo, esat;
    if (rst) sq.delete();
    else begin
      for (int d = 0; d < 3; d++) begin
        if (out_valid[d]) begin
          first_n(d, cm(d), f);
          if (f.size() < cm(d))
            fail($sformatf("sb_avail_d%0d", d), $sformatf("result with %0d samples queued, required %0d", f.size(), cm(d)));
          else begin
            model(f, cm(d), accw(d), es, eo, esat);
            chk($sformatf("sb_sum_d%0d", d), osum[d], es);
            chk($sformatf("sb_ovf_d%0d", d), out_ovf[d], eo);
            chk($sformatf("sb_sat_d%0d", d), out_sat[d], esat);
          end
          if (out_ready[d] && enable[d]) begin
            drop_n(d, cm(d));
            frames[d]++;
          end
        end
        if (in_valid[d] && in_ready[d]) begin
          sq.push_back({2'(d), in_ovf[d], in_data[d]});
          pushes[d]++;
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Must be called just after a posedge; returns just after the accepting edge.
  task automatic send(input int d, input logic [7:0] dat, input logic ov);
    int k;
    in_valid[d] = 1'b1;
    in_data[d]  = dat;
    in_ovf[d]   = ov;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready[d]) break;
    end
    if (k == 300) fail("send_timeout", "in_ready stayed low for 300 cycles, required 1");
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, input string nm);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (out_valid[d]) break;
    end
    if (k == 400) fail(nm, "out_valid stayed low for 400 cycles, required 1");
  endtask

  task automatic finish_frame(input int d);
    sync();
    out_ready[d] = 1'b1;
    sync();
    out_ready[d] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench still running at 400us, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, lat, base, fbase;
    logic signed [31:0] held;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      enable[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = 8'h00;
      in_ovf[d] = 1'b0; out_ready[d] = 1'b0; pushes[d] = 0; frames[d] = 0;
    end
    #3;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_in_ready_d%0d", d), in_ready[d], 0);
      chk($sformatf("rst_out_valid_d%0d", d), out_valid[d], 0);
      chk($sformatf("rst_out_sum_d%0d", d), osum[d], 0);
      chk($sformatf("rst_busy_d%0d", d), busy[d], 0);
      chk($sformatf("rst_flags_d%0d", d), {out_ovf[d], out_sat[d]}, 0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    sync();

    // 1: eight +5 samples, consumer always ready; latency counted from the cycle ending in the first push edge.
    out_ready[0] = 1'b1;
    t0 = cyc;
    fork
      repeat (8) send(0, 8'h05, 1'b0);
      begin
        wait_valid(0, "t1_valid");
        lat = cyc - t0;
        chk("t1_latency", lat, 9);
        chk("t1_sum", osum[0], 40);
        chk("t1_flags", {out_ovf[0], out_sat[0]}, 0);
        chk("t1_busy", busy[0], 1);
        @(negedge clk);
        chk("t1_valid_one_cycle", out_valid[0], 0);
      end
    join
    out_ready[0] = 1'b0;
    sync();

    // 2: mixed signs including negative zero; then overflow flag confined to one frame.
    send(0, 8'h7F, 1'b0); send(0, 8'hFF, 1'b0); send(0, 8'h80, 1'b0); send(0, 8'h83, 1'b0);
    repeat (4) send(0, 8'h01, 1'b0);
    wait_valid(0, "t2_valid");
    chk("t2_sum", osum[0], 1);
    chk("t2_flags", {out_ovf[0], out_sat[0]}, 0);
    finish_frame(0);
    for (int i = 0; i < 8; i++) send(0, 8'h01, i == 2);
    wait_valid(0, "t2b_valid");
    chk("t2b_sum", osum[0], 8);
    chk("t2b_ovf", out_ovf[0], 1);
    finish_frame(0);
    repeat (8) send(0, 8'h02, 1'b0);
    wait_valid(0, "t2c_valid");
    chk("t2c_sum", osum[0], 16);
    chk("t2c_ovf_cleared", out_ovf[0], 0);
    finish_frame(0);

    // 3: 9-bit accumulator clamps both ways.
    repeat (8) send(1, 8'h7F, 1'b0);
    wait_valid(1, "t3_valid");
    chk("t3_sum_max", osum[1], 255);
    chk("t3_sat", out_sat[1], 1);
    finish_frame(1);
    repeat (8) send(1, 8'hFF, 1'b0);
    wait_valid(1, "t3b_valid");
    chk("t3b_sum_min", osum[1], -256);
    chk("t3b_sat", out_sat[1], 1);
    finish_frame(1);

    // 4: consumer stalled while the producer streams 1..16.
    base = pushes[0];
    fork
      for (int i = 1; i <= 16; i++) send(0, 8'(i), 1'b0);
      begin
        repeat (40) @(negedge clk);
        chk("t4_pushes_when_full", pushes[0] - base, 12);
        chk("t4_in_ready_full", in_ready[0], 0);
        chk("t4_valid_held", out_valid[0], 1);
        chk("t4_sum", osum[0], 36);
        repeat (5) @(negedge clk);
        chk("t4_sum_stable", osum[0], 36);
        sync();
        out_ready[0] = 1'b1;
        sync();
        out_ready[0] = 1'b0;
      end
    join
    wait_valid(0, "t4b_valid");
    chk("t4b_sum", osum[0], 100);
    finish_frame(0);

    // 5a: enable low for three cycles mid-frame.
    fork
      repeat (8) send(0, 8'h03, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        enable[0] = 1'b0;
        @(negedge clk);
        held = osum[0];
        base = pushes[0];
        chk("t5_in_ready_low", in_ready[0], 0);
        repeat (2) @(negedge clk);
        chk("t5_acc_frozen", osum[0], held);
        chk("t5_no_push", pushes[0] - base, 0);
        chk("t5_in_ready_low2", in_ready[0], 0);
        sync();
        enable[0] = 1'b1;
      end
    join
    wait_valid(0, "t5_valid");
    chk("t5_sum", osum[0], 24);
    finish_frame(0);

    // 5b: reset while a result is held and two samples are buffered.
    repeat (10) send(0, 8'h05, 1'b0);
    wait_valid(0, "t5b_valid");
    chk("t5b_sum_before", osum[0], 40);
    sync();
    #2;
    rst = 1'b1;
    #1;
    chk("t5b_rst_valid", out_valid[0], 0);
    chk("t5b_rst_sum", osum[0], 0);
    chk("t5b_rst_busy", busy[0], 0);
    chk("t5b_rst_in_ready", in_ready[0], 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    sync();
    repeat (8) send(0, 8'h01, 1'b0);
    wait_valid(0, "t5c_valid");
    chk("t5c_sum_clean", osum[0], 8);
    chk("t5c_flags", {out_ovf[0], out_sat[0]}, 0);
    finish_frame(0);

    // 6: single-sample frames, FIFO filled behind a held result, then drained in order.
    for (int i = 1; i <= 5; i++) send(2, {i[0], 7'(i * 10)}, i == 3);
    @(negedge clk);
    chk("t6_in_ready_full", in_ready[2], 0);
    chk("t6_valid", out_valid[2], 1);
    chk("t6_first_sum", osum[2], -10);
    fbase = frames[2];
    sync();
    out_ready[2] = 1'b1;
    for (int i = 6; i <= 11; i++) send(2, {i[0], 7'(i * 10)}, 1'b0);
    for (int k = 0; k < 100 && frames[2] - fbase < 11; k++) @(negedge clk);
    chk("t6_results", frames[2] - fbase, 11);
    chk("t6_leftover", pending(2), 0);
    sync();
    out_ready[2] = 1'b0;
    repeat (3) sync();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
